ysyx_mem_arbiter: RTL

- Shares the single external memory bus (AXI4-Lite-style master) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write).
- Sits between the IFU/LSU request ports and the SoC bus.
- Serializes accesses with one outstanding transaction at a time.
- Latches the winner's address at grant and returns a one-cycle registered response pulse to the owner.

---
 rtl/ysyx_arb_pkg.sv | 22 ++
 rtl/ysyx_arb_pick.sv | 43 ++++
 rtl/ysyx_mem_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_arb_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner tags, bus response codes.
package ysyx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW,
        B,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        IFU,
        LSU_R,
        LSU_W
    } arb_owner_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_arb_pick.sv
// Combinational request picker: one-hot grant {lsu_w, lsu_r, ifu} plus owner tag.
// ARB_RR_EN: IFU-vs-LSU ties alternate on the last-owner bit; otherwise LSU has fixed priority.
module ysyx_arb_pick
    import ysyx_arb_pkg::*;
(
    input  logic       ifu_req,
    input  logic       lsu_r_req,
    input  logic       lsu_w_req,
`ifdef ARB_RR_EN
    input  logic       last_lsu,
`endif
    output logic [2:0] grant,
    output arb_owner_t owner
);

    logic lsu_req;
    logic lsu_wins;

    always_comb begin
        lsu_req = lsu_r_req | lsu_w_req;
`ifdef ARB_RR_EN
        lsu_wins = lsu_req & (~ifu_req | ~last_lsu);
`else
        lsu_wins = lsu_req;
`endif
        grant = '0;
        owner = NONE;
        // Write always beats read inside the LSU, regardless of arbitration mode.
        if (lsu_wins) begin
            if (lsu_w_req) begin
                grant = 3'b100;
                owner = LSU_W;
            end else begin
                grant = 3'b010;
                owner = LSU_R;
            end
        end else if (ifu_req) begin
            grant = 3'b001;
            owner = IFU;
        end
    end

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Serializes IFU and LSU accesses onto one AXI4-Lite-style bus, one transaction at a time.
// Optional macro ARB_RR_EN selects round-robin IFU/LSU arbitration.
module ysyx_mem_arbiter
    import ysyx_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_rvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic                lsu_rvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [DATA_W-1:0]   up_rdata,
    output logic                up_err,
    output logic [ADDR_W-1:0]   mem_araddr,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [1:0]          mem_rresp,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    input  logic [1:0]          mem_bresp,
    input  logic                mem_bvalid,
    output logic                mem_bready
);

    arb_state_t          state;
    arb_owner_t          owner;
    arb_owner_t          pick_owner;
    logic [2:0]          grant;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done;
    logic                w_done;
    logic                aw_hs;
    logic                w_hs;
`ifdef ARB_RR_EN
    logic                last_lsu;
`endif

    ysyx_arb_pick u_pick (
        .ifu_req   (ifu_arvalid),
        .lsu_r_req (lsu_arvalid),
        .lsu_w_req (lsu_wvalid),
`ifdef ARB_RR_EN
        .last_lsu  (last_lsu),
`endif
        .grant     (grant),
        .owner     (pick_owner)
    );

    assign mem_araddr = addr_q;
    assign mem_awaddr = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
    assign aw_hs      = mem_awvalid & mem_awready;
    assign w_hs       = mem_wvalid & mem_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b0;
            mem_awvalid <= 1'b0;
            mem_wvalid  <= 1'b0;
            mem_bready  <= 1'b0;
            ifu_rvalid  <= 1'b0;
            lsu_rvalid  <= 1'b0;
            lsu_wready  <= 1'b0;
            up_rdata    <= '0;
            up_err      <= 1'b0;
`ifdef ARB_RR_EN
            last_lsu    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner  <= pick_owner;
                        addr_q <= grant[2] ? lsu_awaddr :
                                  grant[1] ? lsu_araddr : ifu_araddr;
`ifdef ARB_RR_EN
                        last_lsu <= ~grant[0];
`endif
                        if (grant[2]) begin
                            wdata_q     <= lsu_wdata;
                            wstrb_q     <= lsu_wstrb;
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                            mem_awvalid <= 1'b1;
                            mem_wvalid  <= 1'b1;
                            state       <= AW;
                        end else begin
                            mem_arvalid <= 1'b1;
                            state       <= AR;
                        end
                    end
                end
                AR: begin
                    if (mem_arready) begin
                        mem_arvalid <= 1'b0;
                        mem_rready  <= 1'b1;
                        state       <= R;
                    end
                end
                R: begin
                    if (mem_rvalid) begin
                        mem_rready <= 1'b0;
                        up_rdata   <= mem_rdata;
                        up_err     <= (mem_rresp != RESP_OKAY);
                        ifu_rvalid <= (owner == IFU);
                        lsu_rvalid <= (owner == LSU_R);
                        state      <= RESP;
                    end
                end
                AW: begin
                    // AW and W complete independently; leave once both have handshaken.
                    if (aw_hs) begin
                        mem_awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_hs) begin
                        mem_wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        mem_bready <= 1'b1;
                        state      <= B;
                    end
                end
                B: begin
                    if (mem_bvalid) begin
                        mem_bready <= 1'b0;
                        up_err     <= (mem_bresp != RESP_OKAY);
                        lsu_wready <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    ifu_rvalid <= 1'b0;
                    lsu_rvalid <= 1'b0;
                    lsu_wready <= 1'b0;
                    up_err     <= 1'b0;
                    owner      <= NONE;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
